// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: FSM encoding and the
// widths of the remaining-cycle counter and the data/address buses.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W           = 4;
  localparam int DATA_W          = 16;
  localparam int ADDR_W          = 16;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Single-port 16-bit word storage with synchronous write and registered read.
// Contents are deliberately never reset.
module mem_array #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : mem_array

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder: accepts one request per LATENCY cycles,
// commits writes on accept and returns read data LATENCY cycles later.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY        = DEFAULT_LATENCY,
  parameter int MEM_WORDS_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                    r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic                      r_wr;
  logic [MEM_WORDS_LOG2-1:0] r_idx;
  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic [MEM_WORDS_LOG2-1:0] w_mem_idx;
  logic                      w_accept;
  logic                      w_we;
  logic                      w_rd_en;
  logic                      r_data_valid;
  logic                      r_have_data;
  logic [DATA_W-1:0]         w_rdata;
  logic                      w_unused_addr_bits;

  // addr[0] and bits above the storage depth only feed this sink
  assign w_unused_addr_bits = ^addr;
  assign w_idx              = addr[MEM_WORDS_LOG2:1];

  assign busy      = (r_state == BUSY) && (r_cnt != '0);
  assign w_accept  = enable && !busy && !rst;
  assign w_we      = w_accept && wr;
  assign w_mem_idx = w_accept ? w_idx : r_idx;

  // The memory read is timed so its registered output lands in the response cycle
  generate
    if (LATENCY == 1) begin : g_rd_now
      assign w_rd_en = w_accept && !wr;
    end else begin : g_rd_late
      assign w_rd_en = (r_state == BUSY) && (r_cnt == CNT_W'(1)) && !r_wr;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = BUSY;
          w_cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (w_accept) begin
          w_cnt_next = CNT_LOAD;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wr         <= 1'b0;
      r_idx        <= '0;
      r_data_valid <= 1'b0;
      r_have_data  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_data_valid <= w_rd_en;
      if (w_accept) begin
        r_wr  <= wr;
        r_idx <= w_idx;
      end
      if (w_rd_en) begin
        r_have_data <= 1'b1;
      end
    end
  end

  mem_array #(
    .ADDR_W (MEM_WORDS_LOG2),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_rd_en),
    .i_addr  (w_mem_idx),
    .i_wdata (data_in),
    .o_rdata (w_rdata)
  );

  // The storage read register has no reset, so mask it until a read has completed
  assign data_out   = r_have_data ? w_rdata : '0;
  assign data_valid = r_data_valid;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut A uses the default latency of 4, dut B uses latency 1
// with a 16-word memory to exercise address wrap.
module tb_data_mem_responder;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        rst_a, en_a, wr_a, busy_a, dv_a;
  logic [15:0] addr_a, din_a, dout_a;
  logic        rst_b, en_b, wr_b, busy_b, dv_b;
  logic [15:0] addr_b, din_b, dout_b;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] last_a = 16'h0000;
  logic [15:0] last_b = 16'h0000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.LATENCY(LAT_A), .MEM_WORDS_LOG2(15)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .wr(wr_a), .addr(addr_a),
    .data_in(din_a), .busy(busy_a), .data_out(dout_a), .data_valid(dv_a)
  );

  data_mem_responder #(.LATENCY(LAT_B), .MEM_WORDS_LOG2(4)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .wr(wr_b), .addr(addr_b),
    .data_in(din_b), .busy(busy_b), .data_out(dout_b), .data_valid(dv_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus on the selected dut; busy is checked mid-cycle and
  // an accepted read pushes its hand-computed response into the scoreboard.
  task automatic drive(input bit sel, input logic r, input logic e, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic exp_busy, input logic [15:0] exp_rd);
    exp_t item;
    if (!sel) begin
      rst_a = r; en_a = e; wr_a = w; addr_a = a; din_a = d;
      if (r) begin qa.delete(); last_a = 16'h0000; end
    end else begin
      rst_b = r; en_b = e; wr_b = w; addr_b = a; din_b = d;
      if (r) begin qb.delete(); last_b = 16'h0000; end
    end
    if (e && !r && !exp_busy) begin
      $display("dut%0d cycle %0d accept %s addr=%h data=%h", sel, cyc, w ? "WR" : "RD", a, w ? d : exp_rd);
      if (!w) begin
        item.data = exp_rd;
        item.cyc  = cyc + (sel ? LAT_B : LAT_A);
        if (!sel) qa.push_back(item);
        else      qb.push_back(item);
      end
    end
    @(negedge clk);
    if (!sel) chk("a_busy", {31'b0, busy_a}, {31'b0, exp_busy});
    else      chk("b_busy", {31'b0, busy_b}, {31'b0, exp_busy});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (dv_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_resp_cycle", cyc, e.cyc);
        chk("a_resp_data", {16'h0, dout_a}, {16'h0, e.data});
        last_a = e.data;
        $display("dut0 cycle %0d response data=%h", cyc, dout_a);
      end
    end else begin
      chk("a_data_out_hold", {16'h0, dout_a}, {16'h0, last_a});
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (dv_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_resp_cycle", cyc, e.cyc);
        chk("b_resp_data", {16'h0, dout_b}, {16'h0, e.data});
        last_b = e.data;
        $display("dut1 cycle %0d response data=%h", cyc, dout_b);
      end
    end else begin
      chk("b_data_out_hold", {16'h0, dout_b}, {16'h0, last_b});
    end
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b1; wr_a = 1'b0; addr_a = 16'h0010; din_a = 16'h0000;
    rst_b = 1'b1; en_b = 1'b1; wr_b = 1'b0; addr_b = 16'h0010; din_b = 16'h0000;
    @(posedge clk);
    #1;

    // dut A: reset held with enable high
    repeat (3) drive(0, 1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
    // c0 write, c1-3 busy, c4 read back
    drive(0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000);
    repeat (3) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    drive(0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF);
    repeat (3) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    // c8: response cycle accepts a write; data_out must keep BEEF
    drive(0, 0, 1, 1, 16'h0020, 16'h5A5A, 0, 16'h0000);
    repeat (3) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    // c12: read with addr[0] set; c14 request while busy is dropped
    drive(0, 0, 1, 0, 16'h0011, 16'h0000, 0, 16'hBEEF);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    drive(0, 0, 1, 0, 16'h0020, 16'h0000, 1, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    drive(0, 0, 1, 0, 16'h0020, 16'h0000, 0, 16'h5A5A);
    repeat (3) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // read in flight, reset two cycles later drops it
    drive(0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    repeat (2) drive(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    repeat (6) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // storage survives reset
    drive(0, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF);
    repeat (3) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
    repeat (2) drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

    // dut B: latency 1, 16-word memory
    repeat (2) drive(1, 1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
    drive(1, 0, 1, 1, 16'h0010, 16'hCAFE, 0, 16'h0000);
    drive(1, 0, 1, 1, 16'h0012, 16'h1357, 0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'hCAFE);
      else            drive(1, 0, 1, 0, 16'h0012, 16'h0000, 0, 16'h1357);
    end
    drive(1, 0, 1, 0, 16'h0030, 16'h0000, 0, 16'hCAFE);
    drive(1, 0, 1, 0, 16'h0032, 16'h0000, 0, 16'h1357);
    repeat (3) drive(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

    chk("a_responses_outstanding", qa.size(), 32'd0);
    chk("b_responses_outstanding", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_mem_responder
